// File: rtl/logic_tester_pkg.sv
// Shared types and the reference gate function for the exhaustive logic tester.
package logic_tester_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // Reduction of the low w bits of v according to op.
  function automatic logic golden(op_e op, logic [15:0] v, int w);
    logic r_and;
    logic r_or;
    logic r_xor;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (int'(i) < w) begin
        r_and = r_and & v[i];
        r_or  = r_or  | v[i];
        r_xor = r_xor ^ v[i];
      end
    end
    case (op)
      OP_AND:  golden = r_and;
      OP_OR:   golden = r_or;
      OP_XOR:  golden = r_xor;
      OP_NAND: golden = ~r_and;
      default: golden = r_and;
    endcase
  endfunction

endpackage

// File: rtl/logic_golden_ref.sv
// Combinational expected output of the gate under test for the current vector.
module logic_golden_ref
  import logic_tester_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] stim,
  output logic             exp_y
);

  // Expected gate output for the driven vector.
  always_comb begin
    exp_y = golden(op, 16'(stim), WIDTH);
  end

endmodule

// File: rtl/logic_exhaustive_tester.sv
// Exhaustive stimulus engine: walks every WIDTH-bit vector, holds each HOLD cycles,
// samples dut_y on the last hold cycle and counts mismatches against the golden gate.
// Optional first-fail capture enabled by defining FIRST_FAIL_CAPTURE_EN.
module logic_exhaustive_tester
  import logic_tester_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int HOLD  = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op_sel,
  output logic [WIDTH-1:0] stim,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fail_vec,
  output logic             fail_vld
);

  localparam int HOLD_W = $clog2(HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  state_e             state;
  state_e             state_nxt;
  op_e                op;
  logic [HOLD_W-1:0]  hold;
  logic               exp_y;
  logic               sample;
  logic               last_sample;
  logic               mismatch;
  logic               launch;
  logic [ERR_W-1:0]   err_nxt;

  logic_golden_ref #(.WIDTH(WIDTH)) u_ref (
    .op    (op),
    .stim  (stim),
    .exp_y (exp_y)
  );

  assign launch      = (state == S_IDLE) && start && !abort;
  assign sample      = (state == S_RUN) && !abort && (hold == HOLD_LAST);
  assign last_sample = sample && (stim == '1);
  assign mismatch    = sample && (dut_y != exp_y);
  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);

  // Saturating error count including the current sample.
  always_comb begin
    err_nxt = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_nxt = err_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: abort wins in RUN; DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_RUN;
      S_RUN: begin
        if (abort)            state_nxt = S_IDLE;
        else if (last_sample) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Vector/hold counters, error count, verdict and latched operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      stim    <= '0;
      hold    <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      op      <= OP_AND;
    end else if (launch) begin
      stim    <= '0;
      hold    <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      op      <= op_e'(op_sel);
    end else if (state == S_RUN) begin
      if (abort) begin
        stim <= '0;
        hold <= '0;
      end else begin
        err_cnt <= err_nxt;
        if (sample) begin
          hold <= '0;
          if (last_sample) begin
            stim <= '0;
            pass <= (err_nxt == '0);
          end else begin
            stim <= stim + 1'b1;
          end
        end else begin
          hold <= hold + 1'b1;
        end
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  // First mismatch of a run is latched; later ones leave it untouched.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      fail_vec <= '0;
      fail_vld <= 1'b0;
    end else if (mismatch && !fail_vld) begin
      fail_vec <= stim;
      fail_vld <= 1'b1;
    end
  end
`else
  assign fail_vec = '0;
  assign fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_logic_exhaustive_tester.sv
// Bench for logic_exhaustive_tester: two instances (2-bit/16-bit counter, 3-bit/1-bit
// counter) against an elapsed-time behavioural model, plus directed literal checks.
module tb_logic_exhaustive_tester;

  localparam int W0   = 2;
  localparam int W1   = 3;
  localparam int HOLD = 4;
`ifdef FIRST_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [2];
  logic       abort [2];
  logic [1:0] op_sel [2];
  int         kind [2];   // 0: AND gate, 1: stuck-at-0

  logic [W0-1:0] stim0, fvec0;
  logic [15:0]   err0;
  logic          busy0, done0, pass0, fvld0, y0;
  logic [W1-1:0] stim1, fvec1;
  logic [0:0]    err1;
  logic          busy1, done1, pass1, fvld1, y1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic bit fake(int k, int v, int w);
    int m;
    m = (1 << w) - 1;
    if (k == 0) return (v & m) == m;
    return 1'b0;
  endfunction

  function automatic bit gold(int op, int v, int w);
    int m;
    bit all1;
    m = (1 << w) - 1;
    all1 = (v & m) == m;
    case (op)
      0: return all1;
      1: return (v & m) != 0;
      2: return ($countones(v & m) % 2) == 1;
      default: return !all1;
    endcase
  endfunction

  always_comb y0 = fake(kind[0], int'(stim0), W0);
  always_comb y1 = fake(kind[1], int'(stim1), W1);

  logic_exhaustive_tester #(.WIDTH(W0), .HOLD(HOLD), .ERR_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .op_sel(op_sel[0]),
    .stim(stim0), .dut_y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fvec0), .fail_vld(fvld0)
  );

  logic_exhaustive_tester #(.WIDTH(W1), .HOLD(HOLD), .ERR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .op_sel(op_sel[1]),
    .stim(stim1), .dut_y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fvec1), .fail_vld(fvld1)
  );

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 done; m_t counts cycles spent in the run.
  int m_ph [2], m_t [2], m_err [2], m_fvec [2], m_op [2];
  bit m_pass [2], m_fvld [2];
  int mw [2]   = '{W0, W1};
  int mmax [2] = '{65535, 1};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ph[i] = 0; m_t[i] = 0; m_err[i] = 0; m_pass[i] = 0; m_fvld[i] = 0; m_fvec[i] = 0;
      end else begin
        case (m_ph[i])
          0: if (start[i] && !abort[i]) begin
            m_ph[i] = 1; m_t[i] = 0; m_err[i] = 0; m_pass[i] = 0;
            m_fvld[i] = 0; m_fvec[i] = 0; m_op[i] = int'(op_sel[i]);
          end
          1: if (abort[i]) begin
            m_ph[i] = 0; m_t[i] = 0;
          end else begin
            int v;
            v = m_t[i] / HOLD;
            if (m_t[i] % HOLD == HOLD - 1) begin
              if (fake(kind[i], v, mw[i]) != gold(m_op[i], v, mw[i])) begin
                if (m_err[i] < mmax[i]) m_err[i]++;
                if (CAP && !m_fvld[i]) begin m_fvld[i] = 1; m_fvec[i] = v; end
              end
              if (v == (1 << mw[i]) - 1) begin
                m_ph[i] = 2; m_pass[i] = (m_err[i] == 0);
              end
            end
            m_t[i]++;
          end
          default: m_ph[i] = 0;
        endcase
      end
    end
  end

  task automatic cmp_inst(input int i, input int st, input logic bz, input logic dn,
                          input logic ps, input int er, input int fv, input logic fl);
    chk("stim", i, st, (m_ph[i] == 1) ? m_t[i] / HOLD : 0);
    chk("busy", i, 32'(bz), 32'(m_ph[i] == 1));
    chk("done", i, 32'(dn), 32'(m_ph[i] == 2));
    chk("pass", i, 32'(ps), 32'(m_pass[i]));
    chk("err_cnt", i, er, m_err[i]);
    chk("fail_vec", i, fv, m_fvec[i]);
    chk("fail_vld", i, 32'(fl), 32'(m_fvld[i]));
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, int'(stim0), busy0, done0, pass0, int'(err0), int'(fvec0), fvld0);
      cmp_inst(1, int'(stim1), busy1, done1, pass1, int'(err1), int'(fvec1), fvld1);
    end
  end

  function automatic logic done_of(input int i);
    return (i == 0) ? done0 : done1;
  endfunction

  // Called at a negedge; returns at the negedge of cycle T0+1.
  task automatic launch(input int i, input logic [1:0] op, input int k);
    op_sel[i] = op;
    kind[i]   = k;
    start[i]  = 1'b1;
    @(negedge clk);
    start[i]  = 1'b0;
  endtask

  // Latency in cycles from the start cycle to the done cycle; -1 on timeout.
  task automatic wait_done(input int i, input int budget, output int lat);
    lat = 1;
    while (!done_of(i) && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!done_of(i)) lat = -1;
  endtask

  task automatic watch_no_done(input int i, input int n);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done_of(i)) seen = 1'b1;
    end
    chk("no_done", i, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    start = '{1'b0, 1'b0};
    abort = '{1'b0, 1'b0};
    op_sel = '{2'd0, 2'd0};
    kind = '{0, 0};
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy0), 0);
    chk("rst_stim", 0, 32'(stim0), 0);
    chk("rst_err", 0, 32'(err0), 0);
    chk("rst_pass", 0, 32'(pass0), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: AND gate under AND golden, clean run.
    launch(0, 2'b00, 0);
    chk("t1_busy", 0, 32'(busy0), 1);
    wait_done(0, 60, lat);
    chk("t1_latency", 0, lat, 17);
    chk("t1_pass", 0, 32'(pass0), 1);
    chk("t1_err", 0, 32'(err0), 0);
    @(negedge clk);
    chk("t1_done_pulse", 0, 32'(done0), 0);

    // T2: stuck-at-0 gate, only vector 11 mismatches.
    launch(0, 2'b00, 1);
    wait_done(0, 60, lat);
    chk("t2_latency", 0, lat, 17);
    chk("t2_err", 0, 32'(err0), 1);
    chk("t2_pass", 0, 32'(pass0), 0);
    chk("t2_fail_vec", 0, 32'(fvec0), CAP ? 3 : 0);
    @(negedge clk);

    // T3: AND gate under OR golden, mismatches at 01 and 10.
    launch(0, 2'b01, 0);
    wait_done(0, 60, lat);
    chk("t3_err", 0, 32'(err0), 2);
    chk("t3_fail_vec", 0, 32'(fvec0), CAP ? 1 : 0);
    chk("t3_fail_vld", 0, 32'(fvld0), 32'(CAP));
    @(negedge clk);

    // T4: abort at T0+6, then a fresh clean run.
    launch(0, 2'b00, 0);
    repeat (5) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("t4_busy", 0, 32'(busy0), 0);
    chk("t4_stim", 0, 32'(stim0), 0);
    watch_no_done(0, 20);
    launch(0, 2'b00, 0);
    wait_done(0, 60, lat);
    chk("t4_rerun_latency", 0, lat, 17);
    chk("t4_rerun_pass", 0, 32'(pass0), 1);
    @(negedge clk);

    // start together with abort in IDLE is ignored.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("sa_idle_busy", 0, 32'(busy0), 0);
    @(negedge clk);

    // T5: 3-input XOR vs stuck-at-0 with a 1-bit saturating counter.
    launch(1, 2'b10, 1);
    wait_done(1, 80, lat);
    chk("t5_latency", 1, lat, 33);
    chk("t5_err", 1, 32'(err1), 1);
    chk("t5_pass", 1, 32'(pass1), 0);
    chk("t5_fail_vec", 1, 32'(fvec1), CAP ? 1 : 0);
    @(negedge clk);

    // T6: start pulse mid-run ignored, then rst at T0+9.
    launch(0, 2'b00, 0);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("t6_busy", 0, 32'(busy0), 1);
    chk("t6_stim", 0, 32'(stim0), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 0, 32'(busy0), 0);
    chk("t6_stim", 0, 32'(stim0), 0);
    chk("t6_pass", 0, 32'(pass0), 0);
    chk("t6_err", 0, 32'(err0), 0);
    watch_no_done(0, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
